seq_restoring_divider: RTL and testbench

//  Multi-cycle unsigned integer divider; the inverse operation of the Wallace multiplier datapath.

---
 rtl/seq_restoring_divider_pkg.sv | 21 ++
 rtl/seq_restoring_divider_if.sv | 34 +++
 rtl/seq_restoring_divider_div_step.sv | 38 +++
 rtl/seq_restoring_divider.sv | 105 ++++++++++
 tb/tb_seq_restoring_divider.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/seq_restoring_divider_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seq_restoring_divider_pkg: state encoding and defaults shared with |
// | the multiplier control.                       Revision: 1.0        |
// +--------------------------------------------------------------------+
package seq_restoring_divider_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int DIV_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } div_state_e;

endpackage
`default_nettype wire

// File: rtl/seq_restoring_divider_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seq_restoring_divider_if: operand/result handshake bundle.         |
// |                                               Revision: 1.0        |
// +--------------------------------------------------------------------+
interface seq_restoring_divider_if
    import seq_restoring_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             busy;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero, busy
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero, busy
    );

endinterface
`default_nettype wire

// File: rtl/seq_restoring_divider_div_step.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | div_step: one restoring-division step using a WIDTH+1 bit ripple   |
// | subtractor.                                   Revision: 1.0        |
// +--------------------------------------------------------------------+
module div_step
    import seq_restoring_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  wire logic [WIDTH-1:0] rem,
    input  wire logic             q_msb,
    input  wire logic [WIDTH-1:0] divisor,
    output logic      [WIDTH-1:0] rem_next,
    output logic                  q_bit
);

    logic [WIDTH:0]   w_t;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH:0]   w_borrow;
    logic             w_borrow_out;

    assign w_t         = {rem, q_msb};
    assign w_borrow[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign w_diff[i]       = w_t[i] ^ divisor[i] ^ w_borrow[i];
        assign w_borrow[i+1]   = (~w_t[i] & divisor[i]) | (~(w_t[i] ^ divisor[i]) & w_borrow[i]);
    end

    // Top bit subtracts an implicit zero divisor bit; only its borrow matters.
    assign w_borrow_out = ~w_t[WIDTH] & w_borrow[WIDTH];

    assign q_bit    = ~w_borrow_out;
    assign rem_next = w_borrow_out ? w_t[WIDTH-1:0] : w_diff;

endmodule
`default_nettype wire

// File: rtl/seq_restoring_divider.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seq_restoring_divider: multi-cycle unsigned restoring divider,     |
// | one quotient bit per clock.                   Revision: 1.0        |
// +--------------------------------------------------------------------+
module seq_restoring_divider
    import seq_restoring_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input wire logic               clk,
    input wire logic               rst_n,
    seq_restoring_divider_if.slave bus
);

    localparam int             CW         = $clog2(WIDTH);
    localparam logic [CW-1:0]  C_CNT_INIT = CW'(WIDTH - 1);

    div_state_e       r_state;
    div_state_e       w_state_next;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_div;
    logic [CW-1:0]    r_cnt;
    logic             r_dbz_pend;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_dbz;
    logic [WIDTH-1:0] w_rem_next;
    logic             w_q_bit;
    logic             w_in_fire;
    logic             w_div_zero;

    assign w_in_fire  = (r_state == S_IDLE) && bus.in_valid;
    assign w_div_zero = (bus.divisor == '0);

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem      (r_rem),
        .q_msb    (r_q[WIDTH-1]),
        .divisor  (r_div),
        .rem_next (w_rem_next),
        .q_bit    (w_q_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE:  if (bus.in_valid)  w_state_next = S_RUN;
            S_RUN:   if (r_cnt == '0)   w_state_next = S_DONE;
            S_DONE:  if (bus.out_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // A zero divisor spends a single RUN cycle so its result appears one cycle after the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem       <= '0;
            r_q         <= '0;
            r_div       <= '0;
            r_cnt       <= '0;
            r_dbz_pend  <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else if (w_in_fire) begin
            r_rem      <= '0;
            r_q        <= bus.dividend;
            r_div      <= bus.divisor;
            r_dbz_pend <= w_div_zero;
            r_cnt      <= w_div_zero ? '0 : C_CNT_INIT;
        end else if (r_state == S_RUN) begin
            r_rem <= w_rem_next;
            r_q   <= {r_q[WIDTH-2:0], w_q_bit};
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - CW'(1);
            end else if (r_dbz_pend) begin
                r_quotient  <= '1;
                r_remainder <= r_q;
                r_dbz       <= 1'b1;
            end else begin
                r_quotient  <= {r_q[WIDTH-2:0], w_q_bit};
                r_remainder <= w_rem_next;
                r_dbz       <= 1'b0;
            end
        end
    end

    assign bus.in_ready    = (r_state == S_IDLE);
    assign bus.out_valid   = (r_state == S_DONE);
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_seq_restoring_divider.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_seq_restoring_divider: directed and randomized checks against   |
// | an arithmetic a/b, a%b model.                 Revision: 1.0        |
// +--------------------------------------------------------------------+
module tb_seq_restoring_divider;

    localparam int W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    logic [W-1:0] exp_q = '0;
    logic [W-1:0] exp_r = '0;
    logic         exp_z = 1'b0;

    seq_restoring_divider_if #(.WIDTH(W)) bus ();

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z);
        if (b == 0) begin
            q = {W{1'b1}};
            r = a;
            z = 1'b1;
        end else begin
            q = W'(int'(a) / int'(b));
            r = W'(int'(a) % int'(b));
            z = 1'b0;
        end
    endfunction

    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            chk("live_quotient", 32'(bus.quotient), 32'(exp_q));
            chk("live_remainder", 32'(bus.remainder), 32'(exp_r));
            chk("live_div_by_zero", 32'(bus.div_by_zero), 32'(exp_z));
            chk("live_in_ready", 32'(bus.in_ready), 0);
        end
    end

    task automatic check_reset_values(input string tag);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 1);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 0);
        chk({tag, "_quotient"}, 32'(bus.quotient), 0);
        chk({tag, "_remainder"}, 32'(bus.remainder), 0);
        chk({tag, "_div_by_zero"}, 32'(bus.div_by_zero), 0);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.in_ready) chk("in_ready_timeout", 32'(bus.in_ready), 1);
        bus.in_valid = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        model(a, b, exp_q, exp_r, exp_z);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.dividend = W'($urandom);
        bus.divisor  = W'($urandom);
    endtask

    // mode 0: out_ready low, 1: high, 2: random with stray in_valid pulses
    task automatic wait_done(input int lat, input int mode);
        int n = 0;
        while (!bus.out_valid && n < 3 * W) begin
            bus.out_ready = (mode == 1) ? 1'b1 : (mode == 2) ? 1'($urandom) : 1'b0;
            if (mode == 2) begin
                bus.in_valid = 1'($urandom);
                bus.dividend = W'($urandom);
                bus.divisor  = W'($urandom);
            end
            @(posedge clk); #1;
            n++;
        end
        bus.in_valid = 1'b0;
        chk("latency", 32'(n), 32'(lat));
        chk("busy_in_done", 32'(bus.busy), 1);
    endtask

    task automatic consume(input int mode, input int hold);
        int  n  = 0;
        bit  hs = 1'b0;
        for (int i = 0; i < hold; i++) begin
            bus.out_ready = 1'b0;
            bus.in_valid  = 1'($urandom);
            bus.dividend  = W'($urandom);
            bus.divisor   = W'($urandom);
            @(posedge clk); #1;
            chk("bp_out_valid", 32'(bus.out_valid), 1);
            chk("bp_in_ready", 32'(bus.in_ready), 0);
        end
        bus.in_valid = 1'b0;
        while (!hs && n < 40) begin
            bus.out_ready = (mode == 2) ? 1'($urandom) : 1'b1;
            hs = bus.out_valid && bus.out_ready;
            @(posedge clk); #1;
            n++;
        end
        if (!hs) chk("out_handshake_timeout", 32'(hs), 1);
        bus.out_ready = 1'b0;
        chk("post_in_ready", 32'(bus.in_ready), 1);
        chk("post_out_valid", 32'(bus.out_valid), 0);
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
    } vec_t;

    initial begin
        vec_t vecs[4];
        logic [W-1:0] a;
        logic [W-1:0] b;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;

        repeat (2) @(posedge clk);
        #1;
        check_reset_values("rst_hold");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check_reset_values("rst_release");

        // 100/7 with out_ready already high as out_valid rises
        issue(8'd100, 8'd7);
        wait_done(W, 1);
        chk("t1_quotient", 32'(bus.quotient), 14);
        chk("t1_remainder", 32'(bus.remainder), 2);
        chk("t1_div_by_zero", 32'(bus.div_by_zero), 0);
        consume(1, 0);

        vecs[0] = '{8'd255, 8'd1,   8'd255, 8'd0};
        vecs[1] = '{8'd3,   8'd200, 8'd0,   8'd3};
        vecs[2] = '{8'd0,   8'd9,   8'd0,   8'd0};
        vecs[3] = '{8'd255, 8'd255, 8'd1,   8'd0};
        foreach (vecs[i]) begin
            issue(vecs[i].a, vecs[i].b);
            wait_done(W, 0);
            chk("dir_quotient", 32'(bus.quotient), 32'(vecs[i].q));
            chk("dir_remainder", 32'(bus.remainder), 32'(vecs[i].r));
            consume(1, 0);
        end

        issue(8'd5, 8'd0);
        wait_done(1, 0);
        chk("dbz_quotient", 32'(bus.quotient), 255);
        chk("dbz_remainder", 32'(bus.remainder), 5);
        chk("dbz_flag", 32'(bus.div_by_zero), 1);
        consume(1, 0);

        issue(8'd77, 8'd5);
        wait_done(W, 0);
        consume(1, 5);
        chk("bp_quotient_held", 32'(bus.quotient), 15);
        chk("bp_remainder_held", 32'(bus.remainder), 2);

        // Reset three cycles into RUN
        issue(8'd200, 8'd3);
        repeat (3) @(posedge clk);
        #1;
        chk("mid_run_busy", 32'(bus.busy), 1);
        rst_n = 1'b0;
        #1;
        check_reset_values("mid_run_rst");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check_reset_values("after_rst");
        issue(8'd50, 8'd6);
        wait_done(W, 0);
        chk("post_rst_quotient", 32'(bus.quotient), 8);
        chk("post_rst_remainder", 32'(bus.remainder), 2);
        consume(1, 0);

        for (int i = 0; i < 1000; i++) begin
            a = W'($urandom);
            case ($urandom_range(0, 7))
                0:       b = '0;
                1:       b = 8'd1;
                2:       b = 8'd255;
                default: b = W'($urandom);
            endcase
            issue(a, b);
            wait_done((b == 0) ? 1 : W, 2);
            consume(2, int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
